move_counter: RTL

MOVE_COUNTER -- requirements
Module: move_counter

---
 rtl/move_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/move_counter.sv
// Cube-move counter: two bouncing pushbuttons (move/undo) are synchronized and debounced,
// and their press pulses step a 4-digit BCD count with a sticky overflow flag.
module move_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       MOVE_KEY,
    input  logic       UNDO_KEY,
    input  logic       CLEAR,
    output logic [3:0] DIGIT0,
    output logic [3:0] DIGIT1,
    output logic [3:0] DIGIT2,
    output logic [3:0] DIGIT3,
    output logic       OVERFLOW
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]     BCD_MAX  = 16'h9999;

    // Bit 0 is the move key, bit 1 the undo key, throughout.
    logic [1:0]    w_key;
    logic [1:0]    r_sync_p0;
    logic [1:0]    r_sync_p1;
    logic [1:0]    r_deb;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];
    logic [15:0]   r_count;
    logic          r_ovf;

    assign w_key = {UNDO_KEY, MOVE_KEY};

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] res;
        logic        borrow;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Stages p0/p1: synchronizer; then debounce, where a change is accepted only after
    // DEBOUNCE_CYCLES consecutive disagreeing samples and a press fires on acceptance of a low.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync_p0 <= 2'b11;
            r_sync_p1 <= 2'b11;
            r_deb     <= 2'b11;
            r_press   <= 2'b00;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
        end else begin
            r_sync_p0 <= w_key;
            r_sync_p1 <= r_sync_p0;
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync_p1[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_cnt[k]   <= '0;
                    r_deb[k]   <= r_sync_p1[k];
                    r_press[k] <= ~r_sync_p1[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    // Count stage: simultaneous move and undo cancel; saturate at both ends.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (CLEAR) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (r_press == 2'b01) begin
            if (r_count == BCD_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= bcd_inc(r_count);
            end
        end else if (r_press == 2'b10) begin
            if (r_count != 16'h0000) begin
                r_count <= bcd_dec(r_count);
            end
        end
    end

    assign DIGIT0   = r_count[3:0];
    assign DIGIT1   = r_count[7:4];
    assign DIGIT2   = r_count[11:8];
    assign DIGIT3   = r_count[15:12];
    assign OVERFLOW = r_ovf;

endmodule
